bin_to_bcd_seq: RTL and testbench

Parametrised sequential binary-to-BCD converter. It uses the shift-and-add-3 (double-dabble) method and replaces the fixed 4-bit "subtract 10 when ≥10" combinational adjust used for two-digit HEX display. It accepts a WIDTH-bit binary value on a start pulse, converts one bit per clock, and presents DIGITS packed BCD digits plus a leading-zero blanking mask for the seven-segment decoders. It sits between switch/counter sources and the HEX decoder bank.

---
 rtl/bin_to_bcd_seq_if.sv | 24 ++
 rtl/bin_to_bcd_seq.sv | 118 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle for the sequential binary-to-BCD converter.
// The master drives start/bin and the slave (converter) drives the results.
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     lz_mask;
  logic                  overflow;

  modport master (
    output start, bin,
    input  busy, done, bcd, lz_mask, overflow
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, lz_mask, overflow
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// start sampled at edge N -> results and a one-cycle done pulse follow edge N+WIDTH+1.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic         clk,
  input  logic         reset,
  bin_to_bcd_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  localparam logic [DIGITS-1:0] LZ_RST = ~DIGITS'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] bin_shift, bin_shift_nxt;
  logic [BW-1:0]   work, work_nxt, adj;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            ovf_work, ovf_work_nxt;
  logic [BW-1:0]   bcd_q, bcd_nxt;
  logic [DIGITS-1:0] lz_q, lz_nxt, lz_calc;
  logic            ovf_q, ovf_nxt;
  logic            done_q, done_nxt;
  logic            all_zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bin_shift <= '0;
      work      <= '0;
      cnt       <= '0;
      ovf_work  <= 1'b0;
      bcd_q     <= '0;
      lz_q      <= LZ_RST;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      bin_shift <= bin_shift_nxt;
      work      <= work_nxt;
      cnt       <= cnt_nxt;
      ovf_work  <= ovf_work_nxt;
      bcd_q     <= bcd_nxt;
      lz_q      <= lz_nxt;
      ovf_q     <= ovf_nxt;
      done_q    <= done_nxt;
    end
  end

  // All digits are adjusted in parallel from their pre-adjust values.
  always_comb begin
    adj = work;
    for (int k = 0; k < DIGITS; k++) begin
      if (work[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = work[4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
    lz_calc  = '0;
    all_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      all_zero   = all_zero & (work[4*k +: 4] == 4'd0);
      lz_calc[k] = all_zero;
    end
  end

  always_comb begin
    state_nxt     = state;
    bin_shift_nxt = bin_shift;
    work_nxt      = work;
    cnt_nxt       = cnt;
    ovf_work_nxt  = ovf_work;
    bcd_nxt       = bcd_q;
    lz_nxt        = lz_q;
    ovf_nxt       = ovf_q;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          bin_shift_nxt = bus.bin;
          work_nxt      = '0;
          ovf_work_nxt  = 1'b0;
          cnt_nxt       = CW'(WIDTH);
          state_nxt     = SHIFT;
        end
      end
      SHIFT: begin
        // A 1 leaving the top digit means the value no longer fits in DIGITS.
        work_nxt      = {adj[BW-2:0], bin_shift[WIDTH-1]};
        bin_shift_nxt = bin_shift << 1;
        if (adj[BW-1])
          ovf_work_nxt = 1'b1;
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1))
          state_nxt = FINISH;
      end
      FINISH: begin
        bcd_nxt   = work;
        lz_nxt    = lz_calc;
        ovf_nxt   = ovf_work;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.lz_mask  = lz_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq in three configurations (8/3, 8/2, 16/5).
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) i3 ();
  bin_to_bcd_seq_if #(.WIDTH(8),  .DIGITS(2)) i2 ();
  bin_to_bcd_seq_if #(.WIDTH(16), .DIGITS(5)) i16 ();

  bin_to_bcd_seq #(.WIDTH(8),  .DIGITS(3)) u3  (.clk(clk), .reset(reset), .bus(i3.slave));
  bin_to_bcd_seq #(.WIDTH(8),  .DIGITS(2)) u2  (.clk(clk), .reset(reset), .bus(i2.slave));
  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) u16 (.clk(clk), .reset(reset), .bus(i16.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decimal digits by repeated division.
  function automatic logic [19:0] dec5(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Issue one conversion on the 8/3 instance; returns edges from sampling edge to done.
  task automatic conv3(input logic [7:0] v, output int lat, output int busy_cnt, output int held_ok);
    logic [11:0] prev;
    prev    = i3.bcd;
    held_ok = 1;
    i3.bin   = v;
    i3.start = 1'b1;
    @(posedge clk); #1;
    i3.start = 1'b0;
    i3.bin   = ~v;
    lat      = 0;
    busy_cnt = int'(i3.busy);
    while (!i3.done && lat < 50) begin
      if (i3.busy && i3.bcd !== prev) held_ok = 0;
      @(posedge clk); #1;
      lat++;
      busy_cnt += int'(i3.busy);
    end
  endtask

  task automatic conv2(input logic [7:0] v, output int lat);
    i2.bin   = v;
    i2.start = 1'b1;
    @(posedge clk); #1;
    i2.start = 1'b0;
    lat = 0;
    while (!i2.done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic conv16(input logic [15:0] v, output int lat);
    i16.bin   = v;
    i16.start = 1'b1;
    @(posedge clk); #1;
    i16.start = 1'b0;
    lat = 0;
    while (!i16.done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, held, ndone, cyc, d1, d2, d3;
    logic [15:0] rv;

    reset = 1'b1;
    i3.start = 1'b0;  i3.bin = '0;
    i2.start = 1'b0;  i2.bin = '0;
    i16.start = 1'b0; i16.bin = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_busy", i3.busy, 1'b0);
    chk("rst_done", i3.done, 1'b0);
    chk("rst_bcd", i3.bcd, 12'h000);
    chk("rst_lz3", i3.lz_mask, 3'b110);
    chk("rst_lz2", i2.lz_mask, 2'b10);
    chk("rst_lz5", i16.lz_mask, 5'b11110);
    chk("rst_ovf", i3.overflow, 1'b0);

    // 255: latency, busy length, hold of outputs during SHIFT
    conv3(8'd255, lat, bc, held);
    chk("lat255", lat, 9);
    chk("busy255", bc, 9);
    chk("hold255", held, 1);
    chk("bcd255", i3.bcd, 12'h255);
    chk("lz255", i3.lz_mask, 3'b000);
    chk("ovf255", i3.overflow, 1'b0);
    @(posedge clk); #1;
    chk("done_pulse", i3.done, 1'b0);
    chk("idle_busy", i3.busy, 1'b0);

    conv3(8'd10, lat, bc, held);
    chk("bcd10", i3.bcd, 12'h010);
    chk("lz10", i3.lz_mask, 3'b100);

    for (int v = 0; v < 16; v++) begin
      conv3(8'(v), lat, bc, held);
      chk("sweep_bcd", i3.bcd, 12'((v / 10) * 16 + (v % 10)));
      chk("sweep_lz", i3.lz_mask, (v < 10) ? 3'b110 : 3'b100);
    end

    // Two-digit instance: overflow and recovery
    conv2(8'd100, lat);
    chk("ovf100", i2.overflow, 1'b1);
    chk("bcd100", i2.bcd, 8'h00);
    chk("lz100", i2.lz_mask, 2'b10);
    conv2(8'd99, lat);
    chk("ovf99", i2.overflow, 1'b0);
    chk("bcd99", i2.bcd, 8'h99);
    chk("lz99", i2.lz_mask, 2'b00);
    conv2(8'd255, lat);
    chk("ovf255_d2", i2.overflow, 1'b1);
    chk("bcd255_d2", i2.bcd, 8'h55);

    // Second start while busy must be ignored
    @(posedge clk); #1;
    i3.bin = 8'd42; i3.start = 1'b1;
    @(posedge clk); #1;
    i3.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    i3.bin = 8'd7; i3.start = 1'b1;
    @(posedge clk); #1;
    i3.start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      ndone += int'(i3.done);
    end
    chk("ign_ndone", ndone, 1);
    chk("ign_bcd", i3.bcd, 12'h042);

    // start held high: back-to-back conversions, one IDLE cycle between
    i3.bin = 8'd123; i3.start = 1'b1;
    ndone = 0; d1 = 0; d2 = 0; d3 = 0; cyc = 0;
    repeat (30) begin
      @(posedge clk); #1;
      cyc++;
      if (i3.done) begin
        ndone++;
        if (ndone == 1) d1 = cyc;
        else if (ndone == 2) d2 = cyc;
        else if (ndone == 3) d3 = cyc;
      end
    end
    i3.start = 1'b0;
    chk("held_ndone", ndone, 3);
    chk("held_period1", d2 - d1, 10);
    chk("held_period2", d3 - d2, 10);
    chk("held_bcd", i3.bcd, 12'h123);
    cyc = 0;
    while (i3.busy && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("held_drain", i3.busy, 1'b0);

    // Asynchronous reset in the middle of SHIFT iteration 4
    i3.bin = 8'd200; i3.start = 1'b1;
    @(posedge clk); #1;
    i3.start = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_busy", i3.busy, 1'b0);
    chk("arst_bcd", i3.bcd, 12'h000);
    chk("arst_lz", i3.lz_mask, 3'b110);
    chk("arst_ovf", i3.overflow, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      ndone += int'(i3.done);
    end
    chk("arst_nodone", ndone, 0);
    conv3(8'd200, lat, bc, held);
    chk("lat200", lat, 9);
    chk("bcd200", i3.bcd, 12'h200);
    chk("lz200", i3.lz_mask, 3'b000);

    // 16-bit / 5-digit: corners then random values
    conv16(16'd0, lat);
    chk("w16_lat0", lat, 17);
    chk("w16_bcd0", i16.bcd, 20'h00000);
    chk("w16_lz0", i16.lz_mask, 5'b11110);
    conv16(16'd65535, lat);
    chk("w16_lat_max", lat, 17);
    chk("w16_bcd_max", i16.bcd, 20'h65535);
    chk("w16_ovf_max", i16.overflow, 1'b0);
    for (int n = 0; n < 1000; n++) begin
      rv = 16'($urandom_range(0, 65535));
      conv16(rv, lat);
      chk("w16_lat", lat, 17);
      chk("w16_bcd", i16.bcd, dec5(int'(rv)));
      chk("w16_ovf", i16.overflow, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
